fp_add_round_normalize: RTL and testbench
=========================================

Name: fp_add_round_normalize

Overview:
- Sequential post-adder stage of the single-precision adder. Sits directly downstream of the mantissa add/subtract stage (stage 3) and replaces the combinational stage4/stage5 pair.
- Takes the raw signed-magnitude sum, the larger exponent and the guard/round/sticky bits, then normalises iteratively (one bit per cycle).
- Rounds to nearest-even, handles overflow, underflow and special inputs, and emits a packed IEEE-754 word over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, packed output width
- MENT_WIDTH, 23, stored fraction width
- EXPO_WIDTH, 8, exponent width

Ports:
- clk_in, input, 1, clock; all state changes on the rising edge
- rst_n_in, input, 1, asynchronous active-low reset
- valid_in, input, 1, upstream result valid
- ready_out, output, 1, block can accept a result
- sign_in, input, 1, result sign
- exponent_in, input, EXPO_WIDTH, bigger exponent from stage 1
- mentissa_in, input, MENT_WIDTH+2, bit 24 = carry, bit 23 = hidden bit, bits 22:0 = fraction
- grs_in, input, 3, guard/round/sticky from the alignment shift
- valid_out, output, 1, floating_addition_out valid
- ready_in, input, 1, downstream accepts the result
- floating_addition_out, output, DATA_WIDTH, {sign, exponent, fraction}

Behaviour:
- Reset (async, rst_n_in=0):
  - State = IDLE; valid_out = 0; ready_out = 0; floating_addition_out = 0; internal registers = 0.
  - ready_out rises on the first clock edge after reset release.
  - Reset asserted mid-operation aborts the transaction; no partial result is emitted.
- Working registers:
  - W = {mentissa_in, grs_in}, 28 bits: bit 27 carry, bit 26 hidden, bits 25:3 fraction, bits 2:0 G/R/S.
  - E = exponent_in, zero-extended to EXPO_WIDTH+2 bits.
- IDLE:
  - ready_out = 1.
  - The handshake (valid_in & ready_out) captures W, E and sign; ready_out drops to 0 on that same edge.
  - If exponent_in = all ones, go to DONE with the result {sign_in, 8'hFF, mentissa_in[22:0]} (Inf/NaN passthrough).
  - Else if W == 0, go to DONE with signed zero {sign_in, 31'b0}.
  - Otherwise go to NORM.
- NORM (one action per cycle):
  - If W[27]=1: W = W >> 1 with the shifted-out bit ORed into W[0]; E = E+1; go to ROUND.
  - Else if W[26]=0: if E <= 1, underflow — flush to {sign, 31'b0} and go to DONE (no denormals). Otherwise W = W << 1, E = E-1, stay in NORM.
  - Else (W[26]=1): go to ROUND.
- ROUND (round-to-nearest-even):
  - inc = W[2] & (W[1] | W[0] | W[3]).
  - M = W[26:3] + inc.
  - If M overflows 24 bits: M = 24'h800000 and E = E+1.
  - If E >= 255: result = {sign, 8'hFF, 23'b0} (infinity). Otherwise result = {sign, E[7:0], M[22:0]}.
  - Go to DONE.
- DONE:
  - valid_out = 1; floating_addition_out is registered and held stable while valid_out=1 & ready_in=0.
  - On valid_out & ready_in: valid_out drops to 0, ready_out rises to 1, go to IDLE.
  - At most one transaction is in flight.
- Latency (handshake edge to valid_out high):
  - Carry or already normalised: 3 edges.
  - k left shifts: 3+k edges.
  - Zero or special input: 1 edge.
  - Underflow: (shifts until E reaches 1) + 2 edges.
- Inputs are ignored while ready_out=0.

Test Plan:
- 1.0+1.0: sign 0, exp 127, mentissa 25'h1000000, grs 0 -> 0x40000000; valid_out high 3 edges after capture.
- RNE ties:
  - exp 127, mentissa 25'h0800001, grs 3'b100 -> 0x3F800002.
  - mentissa 25'h0800002, grs 3'b100 -> 0x3F800002 (tie to even, no increment).
  - mentissa 25'h0FFFFFF, grs 3'b110 -> 0x40000000 (mantissa carry, exp +1).
- Cancellation: exp 127, mentissa 25'h0000001, grs 0 -> 23 shifts, 0x34000000, latency 26 edges.
- Range limits:
  - exp 254, mentissa 25'h1FFFFFF -> 0x7F800000.
  - sign 1, exp 3, mentissa 25'h0000100 -> 0x80000000 (underflow flush).
  - mentissa 0, grs 0 -> 0x00000000 after 1 edge.
- Special input: exp 8'hFF, fraction 23'h400000 -> 0x7FC00000 passthrough.
- Handshake/reset:
  - Hold ready_in=0 for 5 cycles in DONE -> output and valid_out stable; ready_out stays 0.
  - Assert rst_n_in during NORM -> outputs return to 0 immediately; ready_out rises 1 edge after release.

Source files
------------

// File: rtl/fp_add_round_normalize_if.sv
// Handshake and data bundle between the mantissa add stage and the round/normalise stage.
// Master is the upstream/downstream environment, slave is the round/normalise block.
interface fp_add_round_normalize_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MENT_WIDTH = 23,
    parameter int unsigned EXPO_WIDTH = 8
);

    logic                    valid_in;
    logic                    ready_out;
    logic                    sign_in;
    logic [EXPO_WIDTH-1:0]   exponent_in;
    logic [MENT_WIDTH+1:0]   mentissa_in;
    logic [2:0]              grs_in;
    logic                    valid_out;
    logic                    ready_in;
    logic [DATA_WIDTH-1:0]   floating_addition_out;

    modport master (
        output valid_in,
        output sign_in,
        output exponent_in,
        output mentissa_in,
        output grs_in,
        output ready_in,
        input  ready_out,
        input  valid_out,
        input  floating_addition_out
    );

    modport slave (
        input  valid_in,
        input  sign_in,
        input  exponent_in,
        input  mentissa_in,
        input  grs_in,
        input  ready_in,
        output ready_out,
        output valid_out,
        output floating_addition_out
    );

endinterface

// File: rtl/fp_add_round_normalize.sv
// Sequential post-adder stage: iterative normalisation (one bit per cycle), round-to-nearest-even,
// overflow/underflow/special handling, and a registered IEEE-754 result over valid/ready.
module fp_add_round_normalize #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MENT_WIDTH = 23,
    parameter int unsigned EXPO_WIDTH = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    fp_add_round_normalize_if.slave     bus
);

    localparam int unsigned W_WIDTH = MENT_WIDTH + 5;
    localparam int unsigned E_WIDTH = EXPO_WIDTH + 2;

    localparam logic [E_WIDTH-1:0] E_ONE = E_WIDTH'(1);
    localparam logic [E_WIDTH-1:0] E_INF = E_WIDTH'((1 << EXPO_WIDTH) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [W_WIDTH-1:0]      w_q, w_d;
    logic [E_WIDTH-1:0]      e_q, e_d;
    logic                    sign_q, sign_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;

    logic                    round_inc;
    logic                    round_carry;
    logic [MENT_WIDTH-1:0]   frac_rnd;
    logic [E_WIDTH-1:0]      e_rnd;

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= StIdle;
            w_q      <= '0;
            e_q      <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            e_q      <= e_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Round-to-nearest-even on the normalised significand; carry out means all-ones fraction
    always_comb begin
        round_inc   = w_q[2] & (w_q[1] | w_q[0] | w_q[3]);
        round_carry = (&w_q[W_WIDTH-2:3]) & round_inc;
        frac_rnd    = w_q[W_WIDTH-3:3] + MENT_WIDTH'(round_inc);
        e_rnd       = round_carry ? e_q + E_ONE : e_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        e_d      = e_q;
        sign_d   = sign_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (bus.valid_in && ready_q) begin
                    sign_d = bus.sign_in;
                    w_d    = {bus.mentissa_in, bus.grs_in};
                    e_d    = E_WIDTH'(bus.exponent_in);
                    if (bus.exponent_in == '1) begin
                        result_d = {bus.sign_in, bus.exponent_in, bus.mentissa_in[MENT_WIDTH-1:0]};
                        state_d  = StDone;
                    end else if (bus.mentissa_in == '0 && bus.grs_in == '0) begin
                        result_d = {bus.sign_in, {(DATA_WIDTH-1){1'b0}}};
                        state_d  = StDone;
                    end else begin
                        state_d = StNorm;
                    end
                end
            end

            StNorm: begin
                if (w_q[W_WIDTH-1]) begin
                    // Keep the dropped bit alive as sticky
                    w_d     = {1'b0, w_q[W_WIDTH-1:2], w_q[1] | w_q[0]};
                    e_d     = e_q + E_ONE;
                    state_d = StRound;
                end else if (!w_q[W_WIDTH-2]) begin
                    if (e_q <= E_ONE) begin
                        result_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
                        state_d  = StDone;
                    end else begin
                        w_d = w_q << 1;
                        e_d = e_q - E_ONE;
                    end
                end else begin
                    state_d = StRound;
                end
            end

            StRound: begin
                e_d = e_rnd;
                if (e_rnd >= E_INF) begin
                    result_d = {sign_q, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
                end else begin
                    result_d = {sign_q, e_rnd[EXPO_WIDTH-1:0], frac_rnd};
                end
                state_d = StDone;
            end

            StDone: begin
                if (bus.ready_in) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Registered handshake outputs follow the upcoming state
    always_comb begin
        ready_d = (state_d == StIdle);
        valid_d = (state_d == StDone);
    end

    assign bus.ready_out             = ready_q;
    assign bus.valid_out             = valid_q;
    assign bus.floating_addition_out = result_q;

endmodule

// File: tb/tb_fp_add_round_normalize.sv
// Directed self-checking bench for fp_add_round_normalize: results, latencies, handshake, reset.
module tb_fp_add_round_normalize;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int          lat;

    fp_add_round_normalize_if #(
        .DATA_WIDTH(32),
        .MENT_WIDTH(23),
        .EXPO_WIDTH(8)
    ) bus ();

    fp_add_round_normalize #(
        .DATA_WIDTH(32),
        .MENT_WIDTH(23),
        .EXPO_WIDTH(8)
    ) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic s, input logic [7:0] e, input logic [24:0] m,
                          input logic [2:0] g);
        bus.sign_in     = s;
        bus.exponent_in = e;
        bus.mentissa_in = m;
        bus.grs_in      = g;
        bus.valid_in    = 1'b1;
        @(posedge clk_in);
        #1;
        bus.valid_in    = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (!bus.valid_out && l < 100) begin
            @(posedge clk_in);
            #1;
            l++;
        end
    endtask

    task automatic txn(input string tag, input logic s, input logic [7:0] e,
                       input logic [24:0] m, input logic [2:0] g,
                       input logic [31:0] exp_word, input int exp_lat);
        int l;
        check({tag, " ready_before"}, 32'(bus.ready_out), 32'd1);
        launch(s, e, m, g);
        wait_valid(l);
        check({tag, " latency"}, 32'(l), 32'(exp_lat));
        check({tag, " result"}, bus.floating_addition_out, exp_word);
        check({tag, " ready_busy"}, 32'(bus.ready_out), 32'd0);
        @(posedge clk_in);
        #1;
        check({tag, " valid_after"}, 32'(bus.valid_out), 32'd0);
        check({tag, " ready_after"}, 32'(bus.ready_out), 32'd1);
    endtask

    initial begin
        rst_n_in        = 1'b0;
        bus.valid_in    = 1'b0;
        bus.ready_in    = 1'b1;
        bus.sign_in     = 1'b0;
        bus.exponent_in = '0;
        bus.mentissa_in = '0;
        bus.grs_in      = '0;

        #12;
        check("rst valid", 32'(bus.valid_out), 32'd0);
        check("rst ready", 32'(bus.ready_out), 32'd0);
        check("rst out", bus.floating_addition_out, 32'd0);
        rst_n_in = 1'b1;
        #1;
        check("rel ready_pre", 32'(bus.ready_out), 32'd0);
        @(posedge clk_in);
        #1;
        check("rel ready_post", 32'(bus.ready_out), 32'd1);

        txn("one_plus_one", 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h4000_0000, 3);
        txn("tie_odd",      1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F80_0002, 3);
        txn("tie_even",     1'b0, 8'd127, 25'h0800002, 3'b100, 32'h3F80_0002, 3);
        txn("round_carry",  1'b0, 8'd127, 25'h0FFFFFF, 3'b110, 32'h4000_0000, 3);
        txn("cancel",       1'b0, 8'd127, 25'h0000001, 3'b000, 32'h3400_0000, 26);
        txn("overflow",     1'b0, 8'd254, 25'h1FFFFFF, 3'b000, 32'h7F80_0000, 3);
        txn("underflow",    1'b1, 8'd3,   25'h0000100, 3'b000, 32'h8000_0000, 4);
        txn("zero",         1'b0, 8'd100, 25'h0000000, 3'b000, 32'h0000_0000, 1);
        txn("nan_pass",     1'b0, 8'hFF,  25'h0C00000, 3'b000, 32'h7FC0_0000, 1);

        // Downstream stall in DONE
        bus.ready_in = 1'b0;
        launch(1'b0, 8'd127, 25'h0800002, 3'b100);
        wait_valid(lat);
        check("hold latency", 32'(lat), 32'd3);
        repeat (5) begin
            @(posedge clk_in);
            #1;
            check("hold valid", 32'(bus.valid_out), 32'd1);
            check("hold out", bus.floating_addition_out, 32'h3F80_0002);
            check("hold ready", 32'(bus.ready_out), 32'd0);
        end
        bus.ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("hold release valid", 32'(bus.valid_out), 32'd0);
        check("hold release ready", 32'(bus.ready_out), 32'd1);

        // Reset while shifting in NORM
        launch(1'b0, 8'd127, 25'h0000001, 3'b000);
        repeat (4) begin
            @(posedge clk_in);
            #1;
        end
        check("mid busy", 32'(bus.ready_out), 32'd0);
        rst_n_in = 1'b0;
        #1;
        check("mid rst valid", 32'(bus.valid_out), 32'd0);
        check("mid rst ready", 32'(bus.ready_out), 32'd0);
        check("mid rst out", bus.floating_addition_out, 32'd0);
        @(posedge clk_in);
        #1;
        check("mid rst hold ready", 32'(bus.ready_out), 32'd0);
        rst_n_in = 1'b1;
        #1;
        check("mid rel ready_pre", 32'(bus.ready_out), 32'd0);
        @(posedge clk_in);
        #1;
        check("mid rel ready_post", 32'(bus.ready_out), 32'd1);
        check("mid rel valid", 32'(bus.valid_out), 32'd0);

        txn("after_reset", 1'b1, 8'd127, 25'h1000000, 3'b000, 32'hC000_0000, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
